ctrl_decode_pipe: RTL and testbench

Parametrised main control decoder with a registered ID/EX control stage for the pipelined MIPS core. Decodes the 6-bit opcode in the DEC stage into a control bundle and registers it into EX. Supports stall (hold), flush (bubble insertion), an optional extended ISA and an illegal-opcode counter. Replaces the purely combinational main decoder; the ALU decoder consumes `aluop_EX` unchanged.

---
 rtl/ctrl_decode_pipe_pkg.sv | 50 +++++
 rtl/ctrl_decode_pipe_if.sv | 40 ++++
 rtl/ctrl_decode_pipe_decode.sv | 86 ++++++++
 rtl/ctrl_decode_pipe.sv | 81 ++++++++
 tb/tb_ctrl_decode_pipe.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared opcode map, ALU op classes and the control bundle carried from DEC into EX.
package ctrl_pkg;

    localparam int ALUOP_PKG_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [ALUOP_PKG_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALUOP_PKG_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALUOP_PKG_W-1:0] ALU_FUNCT = 3'd2;
    localparam logic [ALUOP_PKG_W-1:0] ALU_AND   = 3'd3;
    localparam logic [ALUOP_PKG_W-1:0] ALU_OR    = 3'd4;
    localparam logic [ALUOP_PKG_W-1:0] ALU_SLT   = 3'd5;
    localparam logic [ALUOP_PKG_W-1:0] ALU_LUI   = 3'd6;

    typedef struct packed {
        logic                   regwrite;
        logic                   memtoreg;
        logic                   memwrite;
        logic                   branch;
        logic                   bne;
        logic                   jump;
        logic                   link;
        logic                   alusrc;
        logic                   zeroext;
        logic                   regdst;
        logic [ALUOP_PKG_W-1:0] aluop;
        logic                   illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Opcodes that only exist when the extended ISA is built in.
    function automatic logic is_ext_op(input logic [5:0] opcode);
        return (opcode == OP_BNE)  || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
               (opcode == OP_SLTI) || (opcode == OP_LUI)  || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// DEC-side request and EX-side control outputs of the decode pipe stage.
interface ctrl_decode_pipe_if #(
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 8
);
    logic [5:0]         opcode_DEC;
    logic               valid_DEC;
    logic               stall_EX;
    logic               flush_EX;

    logic               regwrite_EX;
    logic               memtoreg_EX;
    logic               memwrite_EX;
    logic               branch_EX;
    logic               bne_EX;
    logic               jump_EX;
    logic               link_EX;
    logic               alusrc_EX;
    logic               zeroext_EX;
    logic               regdst_EX;
    logic [ALUOP_W-1:0] aluop_EX;
    logic               valid_EX;
    logic               illegal_EX;
    logic [CNT_W-1:0]   illegal_cnt;

    modport master (
        output opcode_DEC, valid_DEC, stall_EX, flush_EX,
        input  regwrite_EX, memtoreg_EX, memwrite_EX, branch_EX, bne_EX, jump_EX,
               link_EX, alusrc_EX, zeroext_EX, regdst_EX, aluop_EX, valid_EX,
               illegal_EX, illegal_cnt
    );

    modport slave (
        input  opcode_DEC, valid_DEC, stall_EX, flush_EX,
        output regwrite_EX, memtoreg_EX, memwrite_EX, branch_EX, bne_EX, jump_EX,
               link_EX, alusrc_EX, zeroext_EX, regdst_EX, aluop_EX, valid_EX,
               illegal_EX, illegal_cnt
    );

endinterface

// File: rtl/ctrl_decode_pipe_decode.sv
// Combinational main decoder: 6-bit opcode to control bundle.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.aluop    = ALU_FUNCT;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_ADD;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_ADD;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_BNE: begin
                ctrl.branch = 1'b1;
                ctrl.bne    = 1'b1;
                ctrl.aluop  = ALU_SUB;
            end
            OP_ANDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.zeroext  = 1'b1;
                ctrl.aluop    = ALU_AND;
            end
            OP_ORI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.zeroext  = 1'b1;
                ctrl.aluop    = ALU_OR;
            end
            OP_SLTI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_SLT;
            end
            OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALU_LUI;
            end
            OP_JAL: begin
                ctrl.jump     = 1'b1;
                ctrl.link     = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase

        // Without the extension those opcodes fall back to the illegal bundle.
        if (!EXT_ISA && is_ext_op(opcode)) begin
            ctrl         = CTRL_BUBBLE;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID/EX control register around the main decoder, with stall/flush and an
// illegal-opcode counter.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 3,
    parameter bit EXT_ISA = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    ctrl_decode_pipe_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             load;

    ctrl_decode #(.EXT_ISA(EXT_ISA)) u_decode (
        .opcode (bus.opcode_DEC),
        .ctrl   (dec_ctrl)
    );

    always_comb begin
        load    = !bus.flush_EX && !bus.stall_EX;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (bus.flush_EX) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
        end else if (load) begin
            if (bus.valid_DEC) begin
                ctrl_d  = dec_ctrl;
                valid_d = 1'b1;
            end else begin
                ctrl_d  = CTRL_BUBBLE;
                valid_d = 1'b0;
            end
        end

        // Counted only on the cycle the instruction enters EX, so a held
        // instruction is never counted twice.
        if (load && bus.valid_DEC && dec_ctrl.illegal && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.regwrite_EX = ctrl_q.regwrite;
    assign bus.memtoreg_EX = ctrl_q.memtoreg;
    assign bus.memwrite_EX = ctrl_q.memwrite;
    assign bus.branch_EX   = ctrl_q.branch;
    assign bus.bne_EX      = ctrl_q.bne;
    assign bus.jump_EX     = ctrl_q.jump;
    assign bus.link_EX     = ctrl_q.link;
    assign bus.alusrc_EX   = ctrl_q.alusrc;
    assign bus.zeroext_EX  = ctrl_q.zeroext;
    assign bus.regdst_EX   = ctrl_q.regdst;
    assign bus.aluop_EX    = ALUOP_W'(ctrl_q.aluop);
    assign bus.illegal_EX  = ctrl_q.illegal;
    assign bus.valid_EX    = valid_q;
    assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: two builds (extended/8-bit counter and base/2-bit
// counter) driven in lockstep and compared against a table-driven model.
module tb_ctrl_decode_pipe;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       valid;
    logic       stall;
    logic       flush;

    int checks = 0;
    int errors = 0;

    ctrl_decode_pipe_if #(.ALUOP_W(3), .CNT_W(8)) bus0 ();
    ctrl_decode_pipe_if #(.ALUOP_W(2), .CNT_W(2)) bus1 ();

    assign bus0.opcode_DEC = opcode;
    assign bus0.valid_DEC  = valid;
    assign bus0.stall_EX   = stall;
    assign bus0.flush_EX   = flush;
    assign bus1.opcode_DEC = opcode;
    assign bus1.valid_DEC  = valid;
    assign bus1.stall_EX   = stall;
    assign bus1.flush_EX   = flush;

    ctrl_decode_pipe #(.ALUOP_W(3), .EXT_ISA(1'b1), .CNT_W(8)) dut0 (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus0)
    );

    ctrl_decode_pipe #(.ALUOP_W(2), .EXT_ISA(1'b0), .CNT_W(2)) dut1 (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {valid, illegal, aluop[2:0], rw, mtr, mw, br, bne, j, lnk, asrc, zext, rdst}
    logic [14:0] v0, v1;
    assign v0 = {bus0.valid_EX, bus0.illegal_EX, bus0.aluop_EX,
                 bus0.regwrite_EX, bus0.memtoreg_EX, bus0.memwrite_EX, bus0.branch_EX,
                 bus0.bne_EX, bus0.jump_EX, bus0.link_EX, bus0.alusrc_EX,
                 bus0.zeroext_EX, bus0.regdst_EX};
    assign v1 = {bus1.valid_EX, bus1.illegal_EX, 1'b0, bus1.aluop_EX,
                 bus1.regwrite_EX, bus1.memtoreg_EX, bus1.memwrite_EX, bus1.branch_EX,
                 bus1.bne_EX, bus1.jump_EX, bus1.link_EX, bus1.alusrc_EX,
                 bus1.zeroext_EX, bus1.regdst_EX};

    logic [14:0] m_st [2];
    int          m_cnt [2];
    int          cnt_max [2] = '{255, 3};
    bit          ext [2] = '{1'b1, 1'b0};

    // Decode table returning {illegal, aluop[2:0], 10 control bits}.
    function automatic logic [13:0] exp_decode(input logic [5:0] op, input bit e);
        logic [13:0] ill;
        ill = {1'b1, 3'd0, 10'b0000000000};
        case (op)
            6'b000000: return {1'b0, 3'd2, 10'b1000000001};
            6'b100011: return {1'b0, 3'd0, 10'b1100000100};
            6'b101011: return {1'b0, 3'd0, 10'b0010000100};
            6'b000100: return {1'b0, 3'd1, 10'b0001000000};
            6'b001000: return {1'b0, 3'd0, 10'b1000000100};
            6'b000010: return {1'b0, 3'd0, 10'b0000010000};
            6'b000101: return e ? {1'b0, 3'd1, 10'b0001100000} : ill;
            6'b001100: return e ? {1'b0, 3'd3, 10'b1000000110} : ill;
            6'b001101: return e ? {1'b0, 3'd4, 10'b1000000110} : ill;
            6'b001010: return e ? {1'b0, 3'd5, 10'b1000000100} : ill;
            6'b001111: return e ? {1'b0, 3'd6, 10'b1000000100} : ill;
            6'b000011: return e ? {1'b0, 3'd0, 10'b1000011000} : ill;
            default:   return ill;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] op, input bit v, input bit st, input bit fl,
                        input bit rs);
        logic [13:0] d;
        opcode = op;
        valid  = v;
        stall  = st;
        flush  = fl;
        rst_n  = rs;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            d = exp_decode(op, ext[i]);
            if (!rs) begin
                m_st[i]  = '0;
                m_cnt[i] = 0;
            end else if (fl) begin
                m_st[i] = '0;
            end else if (st) begin
                m_st[i] = m_st[i];
            end else if (v) begin
                m_st[i] = {1'b1, d};
                if (d[13] && m_cnt[i] < cnt_max[i]) m_cnt[i]++;
            end else begin
                m_st[i] = '0;
            end
        end
        #1;
        check("ctrl_ext", 32'(v0), 32'(m_st[0]));
        check("ctrl_base", 32'(v1), 32'(m_st[1]));
        check("cnt_ext", 32'(bus0.illegal_cnt), 32'(m_cnt[0]));
        check("cnt_base", 32'(bus1.illegal_cnt), 32'(m_cnt[1]));
    endtask

    logic [5:0] op_tab [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b001000, 6'b000010, 6'b000101, 6'b001100,
                                6'b001101, 6'b001010, 6'b001111, 6'b000011};

    initial begin
        logic [5:0] rop;
        rst_n  = 1'b0;
        opcode = '0;
        valid  = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        m_st   = '{default: '0};
        m_cnt  = '{default: 0};

        step(6'h00, 1, 0, 0, 0);
        step(6'h00, 1, 0, 0, 0);
        check("reset_vec", 32'(v0), 32'd0);
        check("reset_cnt", 32'(bus0.illegal_cnt), 32'd0);

        step(6'b100011, 1, 0, 0, 1);
        check("lw", 32'(v0), 32'(15'b1_0_000_1100000100));

        step(6'b001101, 1, 0, 0, 1);
        check("ori_ext", 32'(v0), 32'(15'b1_0_100_1000000110));
        check("ori_base", 32'(v1), 32'(15'b1_1_000_0000000000));
        check("ori_base_cnt", 32'(bus1.illegal_cnt), 32'd1);

        step(6'b000010, 1, 0, 0, 1);
        check("j", 32'(v0), 32'(15'b1_0_000_0000010000));
        step(6'b000011, 1, 0, 0, 1);
        check("jal", 32'(v0), 32'(15'b1_0_000_1000011000));
        check("jal_base_cnt", 32'(bus1.illegal_cnt), 32'd2);

        step(6'b000000, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(6'b101011, 1, 1, 0, 1);
            check("stall_hold", 32'(v0), 32'(15'b1_0_010_1000000001));
        end
        step(6'b101011, 1, 0, 0, 1);
        check("sw_release", 32'(v0), 32'(15'b1_0_000_0010000100));

        step(6'b000100, 1, 1, 1, 1);
        check("stall_flush", 32'(v0), 32'd0);

        step(6'h00, 0, 0, 0, 0);
        step(6'h3F, 1, 0, 0, 1);
        step(6'h3F, 1, 0, 0, 1);
        step(6'h3F, 1, 0, 0, 1);
        step(6'h3F, 1, 1, 0, 1);
        step(6'h3F, 1, 1, 0, 1);
        step(6'h3F, 1, 0, 0, 1);
        step(6'h3F, 1, 0, 0, 1);
        check("sat_cnt", 32'(bus1.illegal_cnt), 32'd3);
        check("no_recount", 32'(bus0.illegal_cnt), 32'd5);
        step(6'h3F, 1, 1, 0, 0);
        check("reset_cnt_mid", 32'(bus1.illegal_cnt), 32'd0);
        step(6'h3F, 1, 0, 0, 1);
        check("after_reset", 32'(bus1.illegal_cnt), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            rop = ($urandom_range(0, 3) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 11)];
            step(rop, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 99) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
